bist_misr_analyzer: RTL and testbench
=====================================

Name: bist_misr_analyzer

Overview:
Output response analyzer for the BIST loop. It sits directly downstream of the circuit under test and compacts the circuit's response bits (synced_d, sync_err_d) into a multiple-input signature register (MISR) while the BIST controller reports RUNNING. On FINISH it compares the final signature and compaction count against golden constants and drives pass_fail / result_valid to the top level.

Parameters:
RESP_W, 2, width of the response vector; bit0 = synced_d, bit1 = sync_err_d.
SIG_W, 16, MISR width; must satisfy SIG_W >= RESP_W.
POLY, 16'h1021, feedback polynomial taps, SIG_W bits.
SEED, 0, signature value loaded at reset and on INIT.
GOLDEN, 0, expected final signature.
CNT_W, 8, width of the compaction counter.
EXP_CNT, 7, expected number of compacted samples (one LFSR period).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  synchronous reset, active-low.
INIT  in  1  from Bist_control INIT: clear signature and counter, then start a session.
RUNNING  in  1  from Bist_control RUNNING: the current cycle carries valid test response.
FINISH  in  1  from Bist_control FINISH: end of test pattern application.
resp_in  in  RESP_W  circuit-under-test outputs {sync_err_d, synced_d}.
signature  out  SIG_W  current MISR contents.
comp_cnt  out  CNT_W  number of samples compacted in this session.
result_valid  out  1  high in DONE; pass_fail is meaningful only while it is high.
pass_fail  out  1  1 = pass, 0 = fail or no result yet.

Behaviour:
- All state updates occur on the rising CLK edge. RST=0 at an edge has priority over everything: state=IDLE, signature=SEED, comp_cnt=0, result_valid=0, pass_fail=0, resp_q=0, run_q=0.
- Input pipeline: every cycle, resp_q<=resp_in and run_q<=RUNNING. Compaction always uses resp_q/run_q, giving one cycle of latency from a RUNNING sample to the signature update.
- MISR step: sig_next = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(resp_q).
- States:
  - IDLE: holds all outputs. INIT=1 -> signature=SEED, comp_cnt=0, result_valid=0, pass_fail=0; next state COMPACT.
  - COMPACT: if run_q=1, apply one MISR step and increment comp_cnt. comp_cnt saturates at all-ones and does not wrap. FINISH=1 -> next state FLUSH; this cycle's compaction still happens.
  - FLUSH: lasts exactly one cycle. If run_q=1, apply one more MISR step and increment comp_cnt; this captures the sample registered in the same cycle as FINISH. Next state DONE.
  - DONE: on entry, pass_fail <= (signature==GOLDEN) && (comp_cnt==EXP_CNT) and result_valid<=1. Values are evaluated on the final post-FLUSH contents. Outputs hold until INIT or reset. RUNNING and FINISH are ignored.
- INIT=1 in any state other than reset restarts the session: same actions as INIT in IDLE, next state COMPACT. INIT has priority over FINISH in the same cycle.
- While run_q=0 in COMPACT, the signature and counter hold.
- FINISH in IDLE or DONE has no effect.
- A reset mid-session discards the session; no partial result is ever flagged valid.
- result_valid=1 is only reachable through COMPACT -> FLUSH -> DONE.

Test Plan:
1. Reset with RST=0 for 2 cycles -> signature=0x0000, comp_cnt=0, pass_fail=0, result_valid=0; FINISH alone in IDLE keeps result_valid=0.
2. Defaults; INIT; RUNNING=1 for 7 cycles with resp_in=2'b00; FINISH on the 7th cycle -> comp_cnt=7, signature=0x0000. Two cycles after FINISH: result_valid=1, pass_fail=1.
3. INIT; resp_in=2'b01 on the first RUNNING cycle, then 2'b00 for 6 cycles; FINISH -> signature=0x0040, comp_cnt=7, pass_fail=0 (signature mismatch). Repeating with GOLDEN=16'h0040 gives pass_fail=1.
4. Count check: defaults with all-zero response but only 6 RUNNING cycles before FINISH -> comp_cnt=6, pass_fail=0, result_valid=1.
5. Feedback and single-error detection: SEED=16'h8000, one RUNNING cycle with resp_in=2'b10 -> signature=0x1023. Separately, flip resp_in bit1 in one of the 7 cycles of scenario 2 -> pass_fail=0.
6. Controls: assert RST=0 mid-COMPACT -> outputs return to reset values next edge. INIT and FINISH together -> state COMPACT with comp_cnt=0 and result_valid=0. INIT from DONE clears result_valid the next cycle.

Source files
------------

// File: rtl/bist_misr_analyzer.sv
// Output response analyzer for the BIST loop: compacts circuit-under-test responses into a MISR
// while RUNNING, then grades the final signature and sample count against golden constants.
module bist_misr_analyzer #(
    parameter int unsigned       RESP_W  = 2,
    parameter int unsigned       SIG_W   = 16,
    parameter logic [SIG_W-1:0]  POLY    = SIG_W'('h1021),
    parameter logic [SIG_W-1:0]  SEED    = '0,
    parameter logic [SIG_W-1:0]  GOLDEN  = '0,
    parameter int unsigned       CNT_W   = 8,
    parameter logic [CNT_W-1:0]  EXP_CNT = CNT_W'(7)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INIT,
    input  logic              RUNNING,
    input  logic              FINISH,
    input  logic [RESP_W-1:0] resp_in,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  comp_cnt,
    output logic              result_valid,
    output logic              pass_fail
);

    typedef enum logic [1:0] {
        StIdle,
        StCompact,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              pass_q, pass_d;
    logic [RESP_W-1:0] resp_q;
    logic              run_q;

    logic [SIG_W-1:0]  sig_step;
    logic [CNT_W-1:0]  cnt_step;

    // One MISR shift with polynomial feedback, folding in the registered response.
    always_comb begin
        sig_step = {sig_q[SIG_W-2:0], 1'b0}
                 ^ (sig_q[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(resp_q);
        cnt_step = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle: begin
            end
            StCompact: begin
                if (run_q) begin
                    sig_d = sig_step;
                    cnt_d = cnt_step;
                end
                if (FINISH) begin
                    state_d = StFlush;
                end
            end
            // Picks up the sample registered alongside FINISH.
            StFlush: begin
                if (run_q) begin
                    sig_d = sig_step;
                    cnt_d = cnt_step;
                end
                state_d = StDone;
            end
            StDone: begin
                valid_d = 1'b1;
                pass_d  = (sig_q == GOLDEN) && (cnt_q == EXP_CNT);
            end
        endcase

        // A new session overrides whatever the current state would do, FINISH included.
        if (INIT) begin
            state_d = StCompact;
            sig_d   = SEED;
            cnt_d   = '0;
            valid_d = 1'b0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
            sig_q   <= SEED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            resp_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            resp_q  <= resp_in;
            run_q   <= RUNNING;
        end
    end

    assign signature    = sig_q;
    assign comp_cnt     = cnt_q;
    assign result_valid = valid_q;
    assign pass_fail    = pass_q;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Bench for bist_misr_analyzer: vector table, hand sequences for control corners, and randomized
// traffic graded by a session-level model built from a per-edge input history.
module tb_bist_misr_analyzer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        INIT = 1'b0;
    logic        RUNNING = 1'b0;
    logic        FINISH = 1'b0;
    logic [1:0]  resp_in = 2'b00;

    logic [15:0] sig_a, sig_g, sig_s;
    logic [7:0]  cnt_a, cnt_g, cnt_s;
    logic        val_a, val_g, val_s;
    logic        pf_a, pf_g, pf_s;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bist_misr_analyzer u_dut (
        .CLK(CLK), .RST(RST), .INIT(INIT), .RUNNING(RUNNING), .FINISH(FINISH),
        .resp_in(resp_in), .signature(sig_a), .comp_cnt(cnt_a),
        .result_valid(val_a), .pass_fail(pf_a)
    );

    bist_misr_analyzer #(.GOLDEN(16'h0040)) u_dut_g (
        .CLK(CLK), .RST(RST), .INIT(INIT), .RUNNING(RUNNING), .FINISH(FINISH),
        .resp_in(resp_in), .signature(sig_g), .comp_cnt(cnt_g),
        .result_valid(val_g), .pass_fail(pf_g)
    );

    bist_misr_analyzer #(.SEED(16'h8000)) u_dut_s (
        .CLK(CLK), .RST(RST), .INIT(INIT), .RUNNING(RUNNING), .FINISH(FINISH),
        .resp_in(resp_in), .signature(sig_s), .comp_cnt(cnt_s),
        .result_valid(val_s), .pass_fail(pf_s)
    );

    // Model: history of inputs per clock edge plus the edges where the session opened/finished.
    localparam int MAXE = 8192;
    bit       run_h  [MAXE];
    bit [1:0] resp_h [MAXE];
    int       edge_cnt = 0;
    int       sess_start = -1;
    int       sess_finish = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic init, input logic run, input logic fin,
                        input logic [1:0] resp);
        int n;
        RST = rst; INIT = init; RUNNING = run; FINISH = fin; resp_in = resp;
        @(posedge CLK);
        n = edge_cnt;
        if (n < MAXE) begin
            run_h[n]  = run;
            resp_h[n] = resp;
        end
        if (!rst) begin
            sess_start  = -1;
            sess_finish = -1;
        end else if (init) begin
            sess_start  = n;
            sess_finish = -1;
        end else if (fin && sess_start >= 0 && sess_finish < 0) begin
            sess_finish = n;
        end
        edge_cnt++;
        #1;
    endtask

    // Samples present at edges start..finish are compacted, each visible one edge later;
    // the verdict appears two edges after FINISH.
    task automatic model(input int unsigned seed, input int unsigned golden,
                         output int unsigned sig, output int unsigned cnt,
                         output bit valid, output bit pf);
        int last, hi;
        sig = seed; cnt = 0; valid = 0; pf = 0;
        if (sess_start < 0) return;
        last = edge_cnt - 1;
        hi = last - 1;
        if (sess_finish >= 0 && sess_finish < hi) hi = sess_finish;
        for (int e = sess_start; e <= hi; e++) begin
            if (run_h[e]) begin
                sig = sig * 2;
                if (sig >= 32'h10000) sig = (sig - 32'h10000) ^ 32'h1021;
                sig = sig ^ 32'(resp_h[e]);
                cnt++;
            end
        end
        if (cnt > 255) cnt = 255;
        if (sess_finish >= 0 && last >= sess_finish + 2) begin
            valid = 1;
            pf = (sig == golden) && (cnt == 7);
        end
    endtask

    task automatic chk_dut(input string tag, input int unsigned seed, input int unsigned golden,
                           input logic [15:0] sig, input logic [7:0] cnt,
                           input logic valid, input logic pf);
        int unsigned e_sig, e_cnt;
        bit e_valid, e_pf;
        model(seed, golden, e_sig, e_cnt, e_valid, e_pf);
        chk({tag, " signature"}, 32'(sig), e_sig);
        chk({tag, " comp_cnt"}, 32'(cnt), e_cnt);
        chk({tag, " result_valid"}, 32'(valid), 32'(e_valid));
        chk({tag, " pass_fail"}, 32'(pf), 32'(e_pf));
    endtask

    task automatic chk_model(input string tag);
        chk_dut({tag, " dflt"}, 32'h0000, 32'h0000, sig_a, cnt_a, val_a, pf_a);
        chk_dut({tag, " gold40"}, 32'h0000, 32'h0040, sig_g, cnt_g, val_g, pf_g);
        chk_dut({tag, " seed8000"}, 32'h8000, 32'h0000, sig_s, cnt_s, val_s, pf_s);
    endtask

    typedef struct {
        string      name;
        int         n_run;
        int         err_idx;
        logic [1:0] err_val;
        logic [15:0] exp_sig;
        int         exp_cnt;
        bit         exp_pf;
        bit         exp_pf_g;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{"zeros7",     7, -1, 2'b00, 16'h0000, 7, 1'b1, 1'b0};
        tbl[1] = '{"one_first",  7,  0, 2'b01, 16'h0040, 7, 1'b0, 1'b1};
        tbl[2] = '{"zeros6",     6, -1, 2'b00, 16'h0000, 6, 1'b0, 1'b0};
        tbl[3] = '{"err_bit1",   7,  3, 2'b10, 16'h0010, 7, 1'b0, 1'b0};
        tbl[4] = '{"both_first", 7,  0, 2'b11, 16'h00c0, 7, 1'b0, 1'b0};

        // Reset and FINISH with no session open.
        step(0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 0, 2'b00);
        chk("rst signature", 32'(sig_a), 32'h0000);
        chk("rst comp_cnt", 32'(cnt_a), 32'h0);
        chk("rst result_valid", 32'(val_a), 32'h0);
        chk("rst pass_fail", 32'(pf_a), 32'h0);
        chk("rst seed signature", 32'(sig_s), 32'h8000);
        step(1, 0, 0, 1, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        chk("idle finish result_valid", 32'(val_a), 32'h0);

        foreach (tbl[k]) begin
            step(1, 1, 0, 0, 2'b00);
            for (int i = 0; i < tbl[k].n_run; i++) begin
                step(1, 0, 1, (i == tbl[k].n_run - 1),
                     (i == tbl[k].err_idx) ? tbl[k].err_val : 2'b00);
            end
            step(1, 0, 0, 0, 2'b00);
            chk({tbl[k].name, " valid one after finish"}, 32'(val_a), 32'h0);
            step(1, 0, 0, 0, 2'b00);
            chk({tbl[k].name, " signature"}, 32'(sig_a), 32'(tbl[k].exp_sig));
            chk({tbl[k].name, " comp_cnt"}, 32'(cnt_a), 32'(tbl[k].exp_cnt));
            chk({tbl[k].name, " result_valid"}, 32'(val_a), 32'h1);
            chk({tbl[k].name, " pass_fail"}, 32'(pf_a), 32'(tbl[k].exp_pf));
            chk({tbl[k].name, " pass_fail gold40"}, 32'(pf_g), 32'(tbl[k].exp_pf_g));
            chk_model(tbl[k].name);
        end

        // Feedback tap: single sample into a seed with the MSB set.
        step(1, 1, 0, 0, 2'b00);
        step(1, 0, 1, 1, 2'b10);
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        chk("feedback signature", 32'(sig_s), 32'h1023);
        chk("feedback comp_cnt", 32'(cnt_s), 32'h1);
        chk("feedback result_valid", 32'(val_s), 32'h1);

        // Mid-session reset; also checks the one-cycle compaction latency.
        step(1, 1, 0, 0, 2'b00);
        step(1, 0, 1, 0, 2'b01);
        step(1, 0, 1, 0, 2'b01);
        step(1, 0, 1, 0, 2'b01);
        chk("latency comp_cnt", 32'(cnt_a), 32'h2);
        chk("latency signature", 32'(sig_a), 32'h0003);
        step(0, 0, 1, 0, 2'b01);
        chk("midreset signature", 32'(sig_a), 32'h0000);
        chk("midreset comp_cnt", 32'(cnt_a), 32'h0);
        chk("midreset result_valid", 32'(val_a), 32'h0);

        // Reach DONE, then INIT+FINISH together must open a fresh session.
        step(1, 1, 0, 0, 2'b00);
        for (int i = 0; i < 7; i++) step(1, 0, 1, (i == 6), 2'b00);
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        chk("pre init_fin result_valid", 32'(val_a), 32'h1);
        step(1, 1, 1, 1, 2'b00);
        chk("init_fin comp_cnt", 32'(cnt_a), 32'h0);
        chk("init_fin result_valid", 32'(val_a), 32'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 2'b00);
        chk("init_fin still compacting cnt", 32'(cnt_a), 32'h3);
        chk("init_fin no result", 32'(val_a), 32'h0);
        step(1, 0, 1, 1, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        chk("done before init valid", 32'(val_a), 32'h1);
        step(1, 1, 0, 0, 2'b00);
        chk("init from done valid", 32'(val_a), 32'h0);
        chk("init from done pass_fail", 32'(pf_a), 32'h0);

        // Counter saturation.
        for (int i = 0; i < 300; i++) step(1, 0, 1, (i == 299), 2'(i % 4));
        step(1, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 2'b00);
        chk("saturate comp_cnt", 32'(cnt_a), 32'hff);
        chk("saturate result_valid", 32'(val_a), 32'h1);
        chk("saturate pass_fail", 32'(pf_a), 32'h0);
        chk_model("saturate");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic r_rst, r_init, r_run, r_fin;
            logic [1:0] r_resp;
            r_rst  = ($urandom_range(0, 99) != 0);
            r_init = ($urandom_range(0, 24) == 0);
            r_fin  = ($urandom_range(0, 11) == 0);
            r_run  = ($urandom_range(0, 3) != 0);
            r_resp = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
            step(r_rst, r_init, r_run, r_fin, r_resp);
            chk_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
